qsn_sched_len15: RTL and testbench
==================================

Name: qsn_sched_len15

Overview:
- Issue scheduler and select-decoder for the 15-wide, 4-bit-plane QSN cyclic shifter (shift network plus merge stage).
- Arbitrates round-robin between two message-pass requesters (R0 = variable-node pass, R1 = check-node pass).
- Translates a shift factor s into left/right/merge select words and drives the QSN data inputs.
- Tracks each in-flight transfer through the fixed QSN latency so results return tagged with source and tag.

Parameters:
- Z, 15, QSN length (expansion factor); legal shifts are 0..Z-1.
- Q, 4, bit planes per message.
- TAG_W, 6, requester tag width.
- QSN_LAT, 2, cycles from select/data issue to registered QSN output valid.

Ports:
- sys_clk  in  1  clock.
- rstn  in  1  reset.
- en  in  1  grant enable; in-flight transfers still drain when low.
- req0_valid  in  1  R0 request.
- req0_ready  out  1  R0 accepted this cycle.
- req0_shift  in  4  R0 shift factor.
- req0_data  in  Z*Q  R0 message; plane b at [Z*b+Z-1:Z*b].
- req0_tag  in  TAG_W  R0 tag.
- req1_valid, req1_ready, req1_shift, req1_data, req1_tag  same widths as R0, for R1.
- qsn_sw_in  out  Z*Q  data to QSN, same plane packing.
- qsn_left_sel  out  4  left network select.
- qsn_right_sel  out  4  right network select.
- qsn_merge_sel  out  Z-1  merge select; 1 = left path.
- out_valid  out  1  QSN sw_out holds a result this cycle.
- out_src  out  1  source of result (0 = R0, 1 = R1).
- out_tag  out  TAG_W  tag of result.
- inflight  out  2  transfers issued and not yet returned.
- err_shift  out  1  sticky illegal-shift flag.

Behaviour:
- Reset: rstn is synchronous, active-low, on sys_clk. All outputs reset to 0, pointer = R0, pipeline valids cleared. Reset mid-flight discards all in-flight transfers; no out_valid for them.
- Arbitration (combinational, cycle T):
  - If en = 1, grant one valid requester. If both are valid, grant the one the pointer selects.
  - After any grant, the pointer moves to the other requester.
  - reqX_ready = grant to X. No grant when en = 0.
  - Ready never depends on out-side state; QSN has no stall.
- Issue (registered, cycle T+1):
  - qsn_sw_in = granted data.
  - s = 0: left_sel = 0, right_sel = 0, merge_sel = all 0.
  - s = 1..14: left_sel = s, right_sel = Z-s, merge_sel[j] = 1 iff j < Z-s, for j = 0..Z-2.
  - Resulting function: out[j] = in[(j+s) mod Z] per plane.
  - Cycles with no grant: selects and data hold their previous values; the issue-valid bit is 0.
- Illegal shift (s >= Z, i.e. 15): the transfer is still accepted and issued as s = 0. err_shift is set and stays set until reset.
- Return tracking: a QSN_LAT-deep shift register of {valid, src, tag}.
  - Issue at T+1 gives out_valid at T+1+QSN_LAT (T+3 at default), aligned with the registered QSN output.
  - out_src and out_tag are valid only while out_valid = 1 and read 0 otherwise.
- Throughput: one grant per cycle, back-to-back. inflight counts issued-but-unreturned transfers, max QSN_LAT+1 including the issue stage.
  - If an issue and a return occur in the same cycle, inflight is unchanged.
- en deassertion: takes effect the same cycle; already-accepted transfers complete normally.
- One requester valid and the pointer at the other requester: the valid requester is still granted (work-conserving).

Test Plan:
- Identity: R0 shift 0, data plane0 = 0x1234, tag 5. Accept at T. At T+1, left_sel 0, right_sel 0, merge_sel 0x0000. At T+3, out_valid = 1, out_src = 0, out_tag = 5, and the QSN model output equals the input.
- Shift 5: R1 shift 5, plane0 bit 5 set, tag 9. At T+1, left_sel 5, right_sel 10, merge_sel = 0x03FF. QSN output has bit 0 set. out_tag 9, out_src 1.
- Contention: both requesters valid for 4 cycles after reset. Grants go R0, R1, R0, R1 with one ready per cycle. out_src sequence 0, 1, 0, 1 on consecutive cycles; inflight peaks at 3.
- Illegal shift: R0 shift 15. Accepted; selects match the shift-0 case; err_shift = 1 and stays 1 through 10 further legal transfers until reset.
- en gating: en = 0 while R0 is valid gives req0_ready = 0. Raising en grants on the same cycle. Lowering en with 2 in flight still yields 2 out_valid pulses.
- Reset mid-flight: 3 transfers issued, rstn = 0 for 1 cycle. No out_valid afterwards; inflight = 0, pointer = R0, err_shift = 0.

Source files
------------

// File: rtl/qsn_sched_len15_if.sv
// Request/issue/return bundle between the message-pass requesters, the scheduler and the QSN.
// master = requester/observer side, slave = scheduler side.
interface qsn_sched_len15_if #(
    parameter int Z     = 15,
    parameter int Q     = 4,
    parameter int TAG_W = 6
);
    logic             en;
    logic             req0_valid;
    logic             req0_ready;
    logic [3:0]       req0_shift;
    logic [Z*Q-1:0]   req0_data;
    logic [TAG_W-1:0] req0_tag;
    logic             req1_valid;
    logic             req1_ready;
    logic [3:0]       req1_shift;
    logic [Z*Q-1:0]   req1_data;
    logic [TAG_W-1:0] req1_tag;
    logic [Z*Q-1:0]   qsn_sw_in;
    logic [3:0]       qsn_left_sel;
    logic [3:0]       qsn_right_sel;
    logic [Z-2:0]     qsn_merge_sel;
    logic             out_valid;
    logic             out_src;
    logic [TAG_W-1:0] out_tag;
    logic [1:0]       inflight;
    logic             err_shift;

    modport master (
        output en,
        output req0_valid, req0_shift, req0_data, req0_tag,
        output req1_valid, req1_shift, req1_data, req1_tag,
        input  req0_ready, req1_ready,
        input  qsn_sw_in, qsn_left_sel, qsn_right_sel, qsn_merge_sel,
        input  out_valid, out_src, out_tag, inflight, err_shift
    );

    modport slave (
        input  en,
        input  req0_valid, req0_shift, req0_data, req0_tag,
        input  req1_valid, req1_shift, req1_data, req1_tag,
        output req0_ready, req1_ready,
        output qsn_sw_in, qsn_left_sel, qsn_right_sel, qsn_merge_sel,
        output out_valid, out_src, out_tag, inflight, err_shift
    );
endinterface

// File: rtl/qsn_sched_len15.sv
// Round-robin issue scheduler and select decoder for the 15-wide QSN; issue at T+1, result tag at T+1+QSN_LAT.
// No backpressure: the QSN never stalls, so ready is purely the grant and one transfer can issue per cycle.
module qsn_sched_len15 #(
    parameter int Z       = 15,
    parameter int Q       = 4,
    parameter int TAG_W   = 6,
    parameter int QSN_LAT = 2
) (
    input logic              sys_clk,
    input logic              rstn,
    qsn_sched_len15_if.slave bus
);
    logic             ptr;          // 1 = R1 wins on contention
    logic             grant0;
    logic             grant1;
    logic             grant;
    logic [3:0]       g_shift;
    logic [3:0]       s_eff;
    logic             illegal;
    logic [Z*Q-1:0]   g_data;
    logic [TAG_W-1:0] g_tag;
    logic [3:0]       right_nxt;
    logic [Z-2:0]     merge_nxt;

    logic [Z*Q-1:0]     sw_in_q;
    logic [3:0]         left_q;
    logic [3:0]         right_q;
    logic [Z-2:0]       merge_q;
    logic               iss_vld;
    logic               iss_src;
    logic [TAG_W-1:0]   iss_tag;
    logic [QSN_LAT-1:0] ret_vld;
    logic [QSN_LAT-1:0] ret_src;
    logic [TAG_W-1:0]   ret_tag [QSN_LAT];
    logic [1:0]         inflight_q;
    logic               err_q;

    always_comb begin
        grant0    = rstn & bus.en & bus.req0_valid & (~ptr | ~bus.req1_valid);
        grant1    = rstn & bus.en & bus.req1_valid & ~grant0;
        grant     = grant0 | grant1;
        g_shift   = grant1 ? bus.req1_shift : bus.req0_shift;
        g_data    = grant1 ? bus.req1_data  : bus.req0_data;
        g_tag     = grant1 ? bus.req1_tag   : bus.req0_tag;
        // An out-of-range shift is still carried through, as an identity rotation.
        illegal   = (g_shift >= 4'(Z));
        s_eff     = illegal ? 4'd0 : g_shift;
        right_nxt = (s_eff == 4'd0) ? 4'd0 : 4'(Z - int'(s_eff));
        merge_nxt = '0;
        for (int j = 0; j < Z - 1; j++)
            merge_nxt[j] = (s_eff != 4'd0) && (j < (Z - int'(s_eff)));
    end

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            ptr        <= 1'b0;
            sw_in_q    <= '0;
            left_q     <= '0;
            right_q    <= '0;
            merge_q    <= '0;
            iss_vld    <= 1'b0;
            iss_src    <= 1'b0;
            iss_tag    <= '0;
            ret_vld    <= '0;
            ret_src    <= '0;
            for (int k = 0; k < QSN_LAT; k++) ret_tag[k] <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            ptr     <= grant ? grant0 : ptr;
            iss_vld <= grant;
            iss_src <= grant1;
            iss_tag <= grant ? g_tag : '0;
            if (grant) begin
                sw_in_q <= g_data;
                left_q  <= s_eff;
                right_q <= right_nxt;
                merge_q <= merge_nxt;
            end
            err_q      <= err_q | (grant & illegal);
            ret_vld[0] <= iss_vld;
            ret_src[0] <= iss_src;
            ret_tag[0] <= iss_tag;
            for (int k = 1; k < QSN_LAT; k++) begin
                ret_vld[k] <= ret_vld[k-1];
                ret_src[k] <= ret_src[k-1];
                ret_tag[k] <= ret_tag[k-1];
            end
            inflight_q <= inflight_q + 2'(grant) - 2'(ret_vld[QSN_LAT-1]);
        end
    end

    assign bus.req0_ready    = grant0;
    assign bus.req1_ready    = grant1;
    assign bus.qsn_sw_in     = sw_in_q;
    assign bus.qsn_left_sel  = left_q;
    assign bus.qsn_right_sel = right_q;
    assign bus.qsn_merge_sel = merge_q;
    assign bus.out_valid     = ret_vld[QSN_LAT-1];
    assign bus.out_src       = ret_src[QSN_LAT-1];
    assign bus.out_tag       = ret_tag[QSN_LAT-1];
    assign bus.inflight      = inflight_q;
    assign bus.err_shift     = err_q;
endmodule

// File: tb/tb_qsn_sched_len15.sv
// Bench for qsn_sched_len15: directed cases with literal expectations plus a randomized run
// checked every cycle against a transaction-level model of arbitration, rotation and return timing.
module tb_qsn_sched_len15;
    localparam int Z     = 15;
    localparam int Q     = 4;
    localparam int TAG_W = 6;
    localparam int W     = Z * Q;

    logic sys_clk = 1'b0;
    logic rstn;
    always #5 sys_clk = ~sys_clk;

    qsn_sched_len15_if #(.Z(Z), .Q(Q), .TAG_W(TAG_W)) bus ();
    qsn_sched_len15 #(.Z(Z), .Q(Q), .TAG_W(TAG_W), .QSN_LAT(2)) dut (
        .sys_clk (sys_clk),
        .rstn    (rstn),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Left/right rotator pair plus merge, built from the select words alone.
    function automatic logic [W-1:0] qsn_model(input logic [W-1:0] d, input logic [3:0] l,
                                              input logic [3:0] r, input logic [Z-2:0] m);
        logic [W-1:0] o;
        logic lv, rv;
        o = '0;
        for (int b = 0; b < Q; b++)
            for (int j = 0; j < Z; j++) begin
                lv = (j + int'(l) < Z) ? d[b*Z + j + int'(l)] : 1'b0;
                rv = (j >= int'(r))    ? d[b*Z + j - int'(r)] : 1'b0;
                o[b*Z + j] = (j < Z - 1 && m[j]) ? lv : rv;
            end
        return o;
    endfunction

    function automatic logic [W-1:0] rot(input logic [W-1:0] d, input int s);
        logic [W-1:0] o;
        for (int b = 0; b < Q; b++)
            for (int j = 0; j < Z; j++)
                o[b*Z + j] = d[b*Z + (j + s) % Z];
        return o;
    endfunction

    typedef struct {
        int               due;
        logic             src;
        logic [TAG_W-1:0] tag;
        logic [W-1:0]     exp;
    } ret_t;

    ret_t             rq[$];
    logic [W-1:0]     hist [4];
    int               cyc = 0;
    bit               live = 0;
    bit               m_ptr, m_err;
    logic [W-1:0]     e_data;
    logic [3:0]       e_l, e_r;
    logic [Z-2:0]     e_m;
    bit               c_g0, c_g1, c_ev;
    int               c_n, c_s;
    ret_t             c_hit;
    logic [3:0]       c_sh;
    logic [W-1:0]     c_d;
    logic [TAG_W-1:0] c_t;

    // Reference model and per-cycle compare.
    always @(negedge sys_clk) begin
        cyc++;
        c_g0 = 0;
        c_g1 = 0;
        if (rstn && bus.en) begin
            if (bus.req0_valid && bus.req1_valid) begin
                c_g0 = !m_ptr;
                c_g1 = m_ptr;
            end else begin
                c_g0 = bus.req0_valid;
                c_g1 = bus.req1_valid;
            end
        end
        if (live) begin
            check("req0_ready", bus.req0_ready, c_g0);
            check("req1_ready", bus.req1_ready, c_g1);
            check("sw_in", bus.qsn_sw_in, e_data);
            check("left_sel", bus.qsn_left_sel, e_l);
            check("right_sel", bus.qsn_right_sel, e_r);
            check("merge_sel", bus.qsn_merge_sel, e_m);
            hist[cyc % 4] = qsn_model(bus.qsn_sw_in, bus.qsn_left_sel, bus.qsn_right_sel, bus.qsn_merge_sel);
            c_ev = 0;
            c_n  = 0;
            c_hit = '{0, 1'b0, '0, '0};
            foreach (rq[i]) begin
                if (rq[i].due == cyc) begin c_ev = 1; c_hit = rq[i]; end
                if (rq[i].due >= cyc) c_n++;
            end
            check("out_valid", bus.out_valid, c_ev);
            check("out_src", bus.out_src, c_ev ? c_hit.src : 1'b0);
            check("out_tag", bus.out_tag, c_ev ? c_hit.tag : '0);
            check("inflight", bus.inflight, c_n);
            check("err_shift", bus.err_shift, m_err);
            if (c_ev) check("qsn_out", hist[(cyc - 2) % 4], c_hit.exp);
            while (rq.size() > 0 && rq[0].due <= cyc) void'(rq.pop_front());
        end
        if (!rstn) begin
            rq.delete();
            m_ptr  = 0;
            m_err  = 0;
            e_data = '0;
            e_l    = '0;
            e_r    = '0;
            e_m    = '0;
            live   = 1;
        end else if (live && (c_g0 || c_g1)) begin
            c_sh = c_g1 ? bus.req1_shift : bus.req0_shift;
            c_d  = c_g1 ? bus.req1_data  : bus.req0_data;
            c_t  = c_g1 ? bus.req1_tag   : bus.req0_tag;
            c_s  = (int'(c_sh) >= Z) ? 0 : int'(c_sh);
            if (int'(c_sh) >= Z) m_err = 1;
            e_data = c_d;
            e_l    = 4'(c_s);
            e_r    = (c_s == 0) ? 4'd0 : 4'(Z - c_s);
            for (int j = 0; j < Z - 1; j++) e_m[j] = (c_s != 0) && (j < Z - c_s);
            rq.push_back('{cyc + 3, c_g1, c_t, rot(c_d, c_s)});
            m_ptr = !c_g1;
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle_req();
        bus.req0_valid = 0;
        bus.req1_valid = 0;
    endtask

    function automatic logic [W-1:0] rand_data();
        return W'({$urandom, $urandom});
    endfunction

    task automatic set_req(input int p, input logic [3:0] s, input logic [W-1:0] d, input logic [TAG_W-1:0] t);
        if (p == 0) begin
            bus.req0_valid = 1; bus.req0_shift = s; bus.req0_data = d; bus.req0_tag = t;
        end else begin
            bus.req1_valid = 1; bus.req1_shift = s; bus.req1_data = d; bus.req1_tag = t;
        end
    endtask

    task automatic directed(input string nm, input int p, input logic [3:0] s, input logic [W-1:0] d,
                            input logic [TAG_W-1:0] t, input logic [3:0] el, input logic [3:0] er,
                            input logic [Z-2:0] em, input logic [W-1:0] eq);
        tick();
        set_req(p, s, d, t);
        @(negedge sys_clk);
        check({nm, "_ready"}, p == 0 ? bus.req0_ready : bus.req1_ready, 1);
        tick();
        idle_req();
        @(negedge sys_clk);
        check({nm, "_left"}, bus.qsn_left_sel, el);
        check({nm, "_right"}, bus.qsn_right_sel, er);
        check({nm, "_merge"}, bus.qsn_merge_sel, em);
        check({nm, "_qsn"}, qsn_model(bus.qsn_sw_in, bus.qsn_left_sel, bus.qsn_right_sel, bus.qsn_merge_sel), eq);
        tick();
        tick();
        @(negedge sys_clk);
        check({nm, "_ovld"}, bus.out_valid, 1);
        check({nm, "_osrc"}, bus.out_src, p);
        check({nm, "_otag"}, bus.out_tag, t);
    endtask

    int         n, mx;
    logic [3:0] srcs;

    initial begin
        rstn = 0;
        bus.en = 0;
        idle_req();
        bus.req0_shift = 0; bus.req0_data = '0; bus.req0_tag = '0;
        bus.req1_shift = 0; bus.req1_data = '0; bus.req1_tag = '0;
        tick();
        tick();
        rstn = 1;
        @(negedge sys_clk);
        check("rst_inflight", bus.inflight, 0);
        check("rst_merge", bus.qsn_merge_sel, 0);
        bus.en = 1;

        directed("ident", 0, 4'd0, W'(16'h1234), 6'd5, 4'd0, 4'd0, 14'h0000, W'(16'h1234));
        directed("shift5", 1, 4'd5, W'(16'h0020), 6'd9, 4'd5, 4'd10, 14'h03FF, W'(16'h0001));

        // Contention straight out of reset.
        tick(); rstn = 0; tick(); rstn = 1;
        set_req(0, 4'($urandom_range(0, 14)), rand_data(), 6'd1);
        set_req(1, 4'($urandom_range(0, 14)), rand_data(), 6'd2);
        n = 0; mx = 0; srcs = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge sys_clk);
            if (i < 4) begin
                check("cont_r0", bus.req0_ready, (i % 2) == 0);
                check("cont_r1", bus.req1_ready, (i % 2) == 1);
            end
            if (bus.out_valid && n < 4) begin srcs[3 - n] = bus.out_src; n++; end
            if (int'(bus.inflight) > mx) mx = int'(bus.inflight);
            tick();
            if (i == 3) idle_req();
        end
        check("cont_nout", n, 4);
        check("cont_srcs", srcs, 4'b0101);
        check("cont_peak", mx, 3);

        // Illegal shift is issued as identity and latches the sticky flag.
        set_req(0, 4'd15, rand_data(), 6'd3);
        @(negedge sys_clk);
        check("ill_ready", bus.req0_ready, 1);
        tick();
        idle_req();
        @(negedge sys_clk);
        check("ill_left", bus.qsn_left_sel, 0);
        check("ill_right", bus.qsn_right_sel, 0);
        check("ill_merge", bus.qsn_merge_sel, 0);
        check("ill_err", bus.err_shift, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            set_req(0, 4'($urandom_range(0, 14)), rand_data(), 6'($urandom));
        end
        tick();
        idle_req();
        @(negedge sys_clk);
        check("ill_sticky", bus.err_shift, 1);
        repeat (4) tick();

        // en gating: ready follows en in the same cycle, in-flight work drains.
        bus.en = 0;
        set_req(0, 4'd3, rand_data(), 6'd7);
        @(negedge sys_clk);
        check("en_off", bus.req0_ready, 0);
        tick();
        bus.en = 1;
        @(negedge sys_clk);
        check("en_on", bus.req0_ready, 1);
        tick();
        tick();
        bus.en = 0;
        @(negedge sys_clk);
        check("en_drop", bus.req0_ready, 0);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin tick(); @(negedge sys_clk); end
            n += int'(bus.out_valid);
        end
        check("en_drain", n, 2);
        idle_req();
        bus.en = 1;

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            tick();
            bus.en = ($urandom_range(0, 9) != 0);
            bus.req0_valid = $urandom_range(0, 1);
            bus.req1_valid = $urandom_range(0, 1);
            bus.req0_shift = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
            bus.req1_shift = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
            bus.req0_data = rand_data();
            bus.req1_data = rand_data();
            bus.req0_tag = 6'($urandom);
            bus.req1_tag = 6'($urandom);
        end
        tick();
        idle_req();
        bus.en = 1;
        repeat (4) tick();

        // Reset with three transfers in flight.
        for (int i = 0; i < 3; i++) begin
            set_req(0, 4'($urandom_range(1, 14)), rand_data(), 6'(i + 20));
            tick();
        end
        idle_req();
        rstn = 0;
        tick();
        rstn = 1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge sys_clk);
            if (i == 0) begin
                check("mrst_inflight", bus.inflight, 0);
                check("mrst_err", bus.err_shift, 0);
            end
            n += int'(bus.out_valid);
            tick();
        end
        check("mrst_nout", n, 0);
        set_req(0, 4'd1, rand_data(), 6'd1);
        set_req(1, 4'd2, rand_data(), 6'd2);
        @(negedge sys_clk);
        check("mrst_ptr_r0", bus.req0_ready, 1);
        check("mrst_ptr_r1", bus.req1_ready, 0);
        tick();
        idle_req();
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
